t3maps_cmd_shifter: RTL

//  Downstream consumer of the command FIFO (fifo1, read side in the clk_5 domain).

---
 rtl/t3maps_pkg.sv | 16 +
 rtl/t3maps_cmd_shifter_piso_shifter.sv | 39 +++
 rtl/t3maps_cmd_shifter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/t3maps_pkg.sv
// Shared T3MAPS command-path types and widths, common to the FIFOs, the
// control FSM and the command shifter.
package t3maps_pkg;

  localparam int CMD_BYTE_W  = 8;
  localparam int FRAME_LEN_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ACK,
    SHIFT,
    LOAD
  } state_t;

endpackage

// File: rtl/t3maps_cmd_shifter_piso_shifter.sv
// Parallel-in serial-out byte shifter. msb is the register bit currently on the
// wire; zeros are shifted in behind it, so msb reads 0 once the byte is drained.
module piso_shifter
  import t3maps_pkg::*;
#(
  parameter int BYTE_W = CMD_BYTE_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic              msb,
  output logic              last_bit
);

  localparam int CNT_W = $clog2(BYTE_W);

  logic [BYTE_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= CNT_W'(BYTE_W - 1);
    end else if (shift) begin
      shreg <= {shreg[BYTE_W-2:0], 1'b0};
      if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
    end
  end

  assign msb      = shreg[BYTE_W-1];
  assign last_bit = (bit_cnt == '0);

endmodule

// File: rtl/t3maps_cmd_shifter.sv
// Pops a frame of command bytes from fifo1 and shifts them MSB-first into the
// T3MAPS config register, then strobes load to latch it.
module t3maps_cmd_shifter
  import t3maps_pkg::*;
#(
  parameter int BYTE_W      = CMD_BYTE_W,
  parameter int LEN_W       = FRAME_LEN_W,
  parameter int LOAD_CYCLES = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk_5,
  input  logic              Reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [BYTE_W-1:0] fifo_dout,
  input  logic              fifo_rd_ack,
  output logic              fifo_rd_en,
  output logic              sdo,
  output logic              sclk_en,
  output logic              load,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int LDC_W = $clog2(LOAD_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [LDC_W-1:0] LDC_LAST = LDC_W'(LOAD_CYCLES - 1);

  state_t           state;
  logic [LEN_W-1:0] bytes_left;
  logic [TMO_W-1:0] tmo_cnt;
  logic [LDC_W-1:0] ldc_cnt;
  logic             piso_clr;
  logic             piso_load;
  logic             piso_shift;
  logic             last_bit;

  // The shifter register drives sdo directly, so clearing it also forces sdo low.
  assign piso_clr   = Reset || (abort && state != IDLE);
  assign piso_load  = (state == WAIT_ACK) && fifo_rd_ack;
  assign piso_shift = (state == SHIFT);

  piso_shifter #(.BYTE_W(BYTE_W)) u_piso (
    .clk      (clk_5),
    .clr      (piso_clr),
    .load     (piso_load),
    .shift    (piso_shift),
    .din      (fifo_dout),
    .msb      (sdo),
    .last_bit (last_bit)
  );

  always_ff @(posedge clk_5) begin
    if (Reset) begin
      state      <= IDLE;
      bytes_left <= '0;
      tmo_cnt    <= '0;
      ldc_cnt    <= '0;
      fifo_rd_en <= 1'b0;
      sclk_en    <= 1'b0;
      load       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        bytes_left <= '0;
        tmo_cnt    <= '0;
        ldc_cnt    <= '0;
        sclk_en    <= 1'b0;
        load       <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (frame_len != '0) begin
                bytes_left <= frame_len;
                busy       <= 1'b1;
                state      <= FETCH;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FETCH: begin
            // An empty FIFO is an underflow stall; just keep waiting.
            if (!fifo_empty) begin
              fifo_rd_en <= 1'b1;
              tmo_cnt    <= '0;
              state      <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (fifo_rd_ack) begin
              sclk_en <= 1'b1;
              state   <= SHIFT;
            end else if (tmo_cnt == TMO_LAST) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
          SHIFT: begin
            if (last_bit) begin
              sclk_en <= 1'b0;
              if (bytes_left != LEN_W'(1)) begin
                bytes_left <= bytes_left - LEN_W'(1);
                state      <= FETCH;
              end else begin
                bytes_left <= '0;
                load       <= 1'b1;
                ldc_cnt    <= '0;
                state      <= LOAD;
              end
            end
          end
          LOAD: begin
            if (ldc_cnt == LDC_LAST) begin
              load  <= 1'b0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              ldc_cnt <= ldc_cnt + LDC_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
